v_wb_ctrl: RTL

//  Vector writeback controller; drives the write port (vwb_en/addr/data) of the vector register file.

---
 rtl/v_wb_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/v_wb_ctrl.sv
// Vector writeback controller: round-robin merge of ALU/LSU results into a FIFO that drains to the vreg write port.
// One-cycle accept-to-write latency when empty; readies drop only when the FIFO is full (no dependence on same-cycle pop).
`ifndef VREG_WIDTH
`define VREG_WIDTH 128
`endif

module v_wb_ctrl #(
    parameter int DATA_W = `VREG_WIDTH,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid_i,
    input  logic [ADDR_W-1:0]        alu_addr_i,
    input  logic [DATA_W-1:0]        alu_data_i,
    output logic                     alu_ready_o,
    input  logic                     lsu_valid_i,
    input  logic [ADDR_W-1:0]        lsu_addr_i,
    input  logic [DATA_W-1:0]        lsu_data_i,
    output logic                     lsu_ready_o,
    input  logic                     vwb_stall_i,
    output logic                     vwb_en_o,
    output logic [ADDR_W-1:0]        vwb_addr_o,
    output logic [DATA_W-1:0]        vwb_data_o,
    output logic [31:0]              vwb_pending_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_n;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              fav_lsu;
    logic [31:0]       pend_q;
    logic [31:0]       pend_n;
    logic [ADDR_W-1:0] ent_addr;

    logic              space;
    logic              contested;
    logic              alu_grant;
    logic              lsu_grant;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              not_empty;

    assign space     = (count < CW'(DEPTH));
    assign contested = alu_valid_i & lsu_valid_i;
    assign alu_grant = alu_valid_i & (~lsu_valid_i | ~fav_lsu);
    assign lsu_grant = lsu_valid_i & (~alu_valid_i | fav_lsu);

    // Gated by rst so readies read 0 for the whole reset window, not just after the flops clear.
    assign alu_ready_o = alu_grant & space & ~rst;
    assign lsu_ready_o = lsu_grant & space & ~rst;

    assign push      = alu_ready_o | lsu_ready_o;
    assign push_addr = alu_ready_o ? alu_addr_i : lsu_addr_i;
    assign push_data = alu_ready_o ? alu_data_i : lsu_data_i;

    assign not_empty = (count != '0);
    assign pop       = not_empty & ~vwb_stall_i;

    assign vwb_addr_o    = not_empty ? addr_q[rd_ptr] : '0;
    assign vwb_data_o    = not_empty ? data_q[rd_ptr] : '0;
    assign vwb_en_o      = pop & (addr_q[rd_ptr] != '0);
    assign vwb_pending_o = pend_q;
    assign fifo_cnt_o    = count;

    // Next-state occupancy and the pending map it implies, so the map tracks the FIFO edge for edge.
    always_comb begin
        vld_n    = vld_q;
        pend_n   = '0;
        ent_addr = '0;
        if (pop) begin
            vld_n[rd_ptr] = 1'b0;
        end
        if (push) begin
            vld_n[wr_ptr] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr = (push && (PW'(i) == wr_ptr)) ? push_addr : addr_q[i];
            if (vld_n[i]) begin
                pend_n[ent_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            fav_lsu <= 1'b0;
            vld_q   <= '0;
            pend_q  <= '0;
        end else begin
            vld_q  <= vld_n;
            pend_q <= pend_n;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (contested && space) begin
                fav_lsu <= ~fav_lsu;
            end
        end
    end

    // Payload storage needs no reset: it is only observed while the matching count says it is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule
